// File: rtl/flt2int.sv
// Multi-cycle half-precision float to 16-bit signed integer converter, one shift per clock.
// Define ROUND_EN for round-half-to-even; the default build truncates toward zero.
module flt2int #(
    parameter int BIAS = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] flt_in,
    output logic [15:0] int_out,
    output logic        ovf,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

`ifdef ROUND_EN
    localparam logic ROUND_ON = 1'b1;
`else
    localparam logic ROUND_ON = 1'b0;
`endif

    // Exponent landmarks: 0.5, 1.0, 1024 (sig already integral) and the saturating exponent.
    localparam logic [4:0] E_HALF = 5'(BIAS - 1);
    localparam logic [4:0] E_ONE  = 5'(BIAS);
    localparam logic [4:0] E_UNIT = 5'(BIAS + 10);
    localparam logic [4:0] E_MAX  = 5'(BIAS + 15);

    logic [1:0]  state_q, state_d;
    logic [15:0] flt_q, flt_d;
    logic [15:0] mag_q, mag_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic        sat_q, sat_d;
    logic        exact_q, exact_d;
    logic [15:0] int_out_q, int_out_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    logic        sgn;
    logic [4:0]  expo;
    logic [9:0]  mant;
    logic [10:0] sig;

    assign sgn  = flt_q[15];
    assign expo = flt_q[14:10];
    assign mant = flt_q[9:0];
    assign sig  = {1'b1, mant};

    function automatic logic [15:0] round_mag(input logic [15:0] mag, input logic guard,
                                              input logic sticky);
        return mag + {15'd0, ROUND_ON & guard & (sticky | mag[0])};
    endfunction

    function automatic logic [15:0] sat_val(input logic neg);
        return neg ? 16'h8000 : 16'h7FFF;
    endfunction

    function automatic logic [15:0] apply_sign(input logic neg, input logic [15:0] mag);
        logic signed [15:0] smag;
        smag = signed'(mag);
        return neg ? 16'(-smag) : mag;
    endfunction

    always_comb begin
        state_d   = state_q;
        flt_d     = flt_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        sat_d     = sat_q;
        exact_d   = exact_q;
        int_out_d = int_out_q;
        ovf_d     = ovf_q;
        done_d    = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    flt_d   = flt_in;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                mag_d    = 16'd0;
                cnt_d    = 4'd0;
                left_d   = 1'b0;
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                sat_d    = 1'b0;
                exact_d  = 1'b0;
                if (expo == 5'd0) begin
                    mag_d = 16'd0;
                end else if (expo < E_ONE) begin
                    // Only 0.5 <= |x| < 1 can round up to 1; shift it fully into guard/sticky.
                    if (ROUND_ON && expo == E_HALF) begin
                        mag_d = {5'd0, sig};
                        cnt_d = 4'd11;
                    end
                end else if (expo < E_UNIT) begin
                    mag_d = {5'd0, sig};
                    cnt_d = 4'(E_UNIT - expo);
                end else if (expo == E_UNIT) begin
                    mag_d = {5'd0, sig};
                end else if (expo < E_MAX) begin
                    mag_d  = {5'd0, sig};
                    cnt_d  = 4'(expo - E_UNIT);
                    left_d = 1'b1;
                end else if (expo == E_MAX && sgn && mant == 10'd0) begin
                    exact_d = 1'b1;
                end else begin
                    sat_d = 1'b1;
                end
                state_d = (cnt_d == 4'd0) ? FIN : SHIFT;
            end
            SHIFT: begin
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    mag_d    = mag_q >> 1;
                    guard_d  = mag_q[0];
                    sticky_d = sticky_q | guard_q;
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = FIN;
            end
            FIN: begin
                if (sat_q)        int_out_d = sat_val(sgn);
                else if (exact_q) int_out_d = 16'h8000;
                else              int_out_d = apply_sign(sgn, round_mag(mag_q, guard_q, sticky_q));
                ovf_d   = sat_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            int_out_q <= 16'h0000;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            int_out_q <= int_out_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        flt_q    <= flt_d;
        mag_q    <= mag_d;
        cnt_q    <= cnt_d;
        left_q   <= left_d;
        guard_q  <= guard_d;
        sticky_q <= sticky_d;
        sat_q    <= sat_d;
        exact_q  <= exact_d;
    end

    assign int_out = int_out_q;
    assign ovf     = ovf_q;
    assign done    = done_q;

endmodule

// File: tb/tb_flt2int.sv
// Bench for flt2int: scoreboarded conversions, rounding/truncation, handshake and reset abort.
module tb_flt2int;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] flt_in;
    logic [15:0] int_out;
    logic        ovf;
    logic        done;

    int checks;
    int failures;

    typedef struct {
        logic [15:0] flt;
        logic [15:0] val;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];

    flt2int dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flt_in (flt_in),
        .int_out(int_out),
        .ovf    (ovf),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one single-cycle start and waits for done; lat counts edges from the start edge.
    task automatic convert(input logic [15:0] f, output logic [15:0] v, output logic o,
                           output int lat);
        @(negedge clk);
        flt_in = f;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        v = int_out;
        o = ovf;
    endtask

    task automatic run_table(input string tag);
        logic [15:0] v;
        logic        o;
        int          lat;
        exp_t        e;
        while (sb.size() > 0) begin
            convert(sb[0].flt, v, o, lat);
            e = sb.pop_front();
            checks++;
            if (v !== e.val) begin
                failures++;
                $display("FAIL %s_val in=%h got=%h want=%h", tag, e.flt, v, e.val);
            end
            checks++;
            if (o !== e.ovf) begin
                failures++;
                $display("FAIL %s_ovf in=%h got=%b want=%b", tag, e.flt, o, e.ovf);
            end
            checks++;
            if (lat != e.lat) begin
                failures++;
                $display("FAIL %s_lat in=%h got=%0d want=%0d", tag, e.flt, lat, e.lat);
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        flt_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (int_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_int got=%h want=0000", int_out);
        end
        checks++;
        if (ovf !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got ovf=%b done=%b want 0 0", ovf, done);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        sb.push_back('{16'h3C00, 16'h0001, 1'b0, 13});
        sb.push_back('{16'h77FF, 16'h7FF0, 1'b0, 7});
        sb.push_back('{16'h7400, 16'h4000, 1'b0, 7});
        sb.push_back('{16'hC000, 16'hFFFE, 1'b0, 12});
        sb.push_back('{16'h6400, 16'h0400, 1'b0, 3});
        run_table("basic");
    endtask

    task automatic test_special();
        sb.push_back('{16'hF800, 16'h8000, 1'b0, 3});
        sb.push_back('{16'h7800, 16'h7FFF, 1'b1, 3});
        sb.push_back('{16'h7C00, 16'h7FFF, 1'b1, 3});
        sb.push_back('{16'hFC00, 16'h8000, 1'b1, 3});
        sb.push_back('{16'h7E01, 16'h7FFF, 1'b1, 3});
        sb.push_back('{16'h0000, 16'h0000, 1'b0, 3});
        sb.push_back('{16'h8000, 16'h0000, 1'b0, 3});
        sb.push_back('{16'h0001, 16'h0000, 1'b0, 3});
        run_table("special");
    endtask

    task automatic test_round();
`ifdef ROUND_EN
        sb.push_back('{16'h3E00, 16'h0002, 1'b0, 13});
        sb.push_back('{16'hBE00, 16'hFFFE, 1'b0, 13});
        sb.push_back('{16'h3A00, 16'h0001, 1'b0, 14});
        sb.push_back('{16'h3800, 16'h0000, 1'b0, 14});
        sb.push_back('{16'h4100, 16'h0002, 1'b0, 12});
        sb.push_back('{16'h3400, 16'h0000, 1'b0, 3});
`else
        sb.push_back('{16'h3E00, 16'h0001, 1'b0, 13});
        sb.push_back('{16'hBE00, 16'hFFFF, 1'b0, 13});
        sb.push_back('{16'h3A00, 16'h0000, 1'b0, 3});
        sb.push_back('{16'h3800, 16'h0000, 1'b0, 3});
        sb.push_back('{16'h4100, 16'h0002, 1'b0, 12});
        sb.push_back('{16'h3BFF, 16'h0000, 1'b0, 3});
`endif
        run_table("round");
    endtask

    task automatic test_back_to_back();
        int lat;
        // Second start during SHIFT must be ignored.
        sb.push_back('{16'h3C00, 16'h0001, 1'b0, 13});
        @(negedge clk);
        flt_in = 16'h3C00;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
            lat++;
        end
        flt_in = 16'h7400;
        start  = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != sb[0].lat || int_out !== sb[0].val) begin
            failures++;
            $display("FAIL b2b_ignore got lat=%0d val=%h want lat=%0d val=%h",
                     lat, int_out, sb[0].lat, sb[0].val);
        end
        void'(sb.pop_front());
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || int_out !== 16'h0001) begin
            failures++;
            $display("FAIL b2b_hold got done=%b val=%h want done=1 val=0001", done, int_out);
        end

        // Two-cycle start pulse converts exactly once.
        @(negedge clk);
        flt_in = 16'h7800;
        start  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_clear got done=%b want 0", done);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 2;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 3 || int_out !== 16'h7FFF || ovf !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pulse2 got lat=%0d val=%h ovf=%b want lat=3 val=7fff ovf=1",
                     lat, int_out, ovf);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_once got done=%b want 1", done);
        end

        // Start held high re-triggers on the first IDLE edge after FIN.
        @(negedge clk);
        flt_in = 16'h0000;
        start  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || int_out !== 16'h0000 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_held_first got done=%b val=%h ovf=%b want 1 0000 0",
                     done, int_out, ovf);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_retrigger got done=%b want 0", done);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL b2b_retrigger_lat got=%0d want=2", lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        logic        o;
        int          lat;
        @(negedge clk);
        flt_in = 16'h3C00;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || int_out !== 16'h0000 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got done=%b val=%h ovf=%b want 0 0000 0", done, int_out, ovf);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL rst_abort got done=%b want 0", done);
        end
        sb.push_back('{16'h4100, 16'h0002, 1'b0, 12});
        convert(sb[0].flt, v, o, lat);
        checks++;
        if (v !== sb[0].val || o !== sb[0].ovf || lat != sb[0].lat) begin
            failures++;
            $display("FAIL rst_fresh got val=%h ovf=%b lat=%0d want val=%h ovf=%b lat=%0d",
                     v, o, lat, sb[0].val, sb[0].ovf, sb[0].lat);
        end
        void'(sb.pop_front());
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_special();
        test_round();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
